// File: rtl/mat_row_store.sv
// rtl/mat_row_store.sv - row-organised complex matrix scratchpad with engine row port and host element stream
`timescale 1ns/1ps
module mat_row_store #(
    parameter int SIZE  = 16,
    parameter int WIDTH = 64,
    localparam int AW   = $clog2(SIZE),
    localparam int EW   = 2 * WIDTH,
    localparam int RW   = SIZE * EW
) (
    input  logic          clk_i,
    input  logic          rst_ni,
    input  logic          flush_i,
    input  logic [AW-1:0] rd_addr_i,
    input  logic          rd_addr_valid_i,
    output logic [RW-1:0] rd_row_o,
    output logic [AW-1:0] rd_addr_o,
    output logic          rd_row_valid_o,
    input  logic [RW-1:0] wr_row_i,
    input  logic [AW-1:0] wr_addr_i,
    input  logic          wr_valid_i,
    input  logic          load_start_i,
    input  logic [EW-1:0] load_data_i,
    input  logic          load_valid_i,
    output logic          load_ready_o,
    input  logic          dump_start_i,
    output logic [EW-1:0] dump_data_o,
    output logic          dump_valid_o,
    input  logic          dump_ready_i,
    output logic          dump_last_o,
    output logic          busy_o,
    output logic          err_o
);

    typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DUMP} state_t;

    localparam logic [AW-1:0] LAST   = AW'(SIZE - 1);
    localparam logic [AW:0]   SIZE_W = (AW + 1)'(SIZE);

    logic [SIZE-1:0][EW-1:0] mem_q [SIZE];

    state_t        state_q, state_d;
    logic [AW-1:0] r_q, r_d, c_q, c_d;
    logic [EW-1:0] dump_data_q, dump_data_d;
    logic          dump_valid_q, dump_valid_d;
    logic          dump_last_q, dump_last_d;
    logic [RW-1:0] rd_row_q, rd_row_d;
    logic [AW-1:0] rd_addr_q, rd_addr_d;
    logic          rd_valid_q, rd_valid_d;
    logic          err_q, err_d;

    logic          row_we, elem_we;
    logic          rd_ok, wr_ok, at_end;
    logic [AW-1:0] r_step, c_step;

    assign rd_ok  = {1'b0, rd_addr_i} < SIZE_W;
    assign wr_ok  = {1'b0, wr_addr_i} < SIZE_W;
    assign at_end = (r_q == LAST) && (c_q == LAST);

    always_comb begin
        c_step = c_q + AW'(1);
        r_step = r_q;
        if (c_q == LAST) begin
            c_step = '0;
            r_step = (r_q == LAST) ? '0 : r_q + AW'(1);
        end
    end

    always_comb begin
        state_d      = state_q;
        r_d          = r_q;
        c_d          = c_q;
        dump_data_d  = dump_data_q;
        dump_valid_d = dump_valid_q;
        dump_last_d  = dump_last_q;
        rd_row_d     = rd_row_q;
        rd_addr_d    = rd_addr_q;
        rd_valid_d   = 1'b0;
        err_d        = err_q;
        row_we       = 1'b0;
        elem_we      = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (rd_addr_valid_i) begin
                    rd_valid_d = 1'b1;
                    rd_addr_d  = rd_addr_i;
                    rd_row_d   = rd_ok ? RW'(mem_q[rd_addr_i]) : '0;
                    if (!rd_ok) err_d = 1'b1;
                end
                if (wr_valid_i) begin
                    if (wr_ok) row_we = 1'b1;
                    else       err_d  = 1'b1;
                end
                if (load_start_i) begin
                    state_d = S_LOAD;
                    r_d     = '0;
                    c_d     = '0;
                    if (dump_start_i) err_d = 1'b1;
                end else if (dump_start_i) begin
                    state_d = S_DUMP;
                    r_d     = '0;
                    c_d     = '0;
                end
            end
            S_LOAD: begin
                if (rd_addr_valid_i || wr_valid_i) err_d = 1'b1;
                if (load_valid_i) begin
                    elem_we = 1'b1;
                    r_d     = r_step;
                    c_d     = c_step;
                    if (at_end) state_d = S_IDLE;
                end
            end
            S_DUMP: begin
                if (rd_addr_valid_i || wr_valid_i) err_d = 1'b1;
                // r/c point at the next element to prefetch, one ahead of the presented beat
                if (!dump_valid_q || dump_ready_i) begin
                    if (dump_valid_q && dump_last_q) begin
                        state_d      = S_IDLE;
                        dump_valid_d = 1'b0;
                        dump_last_d  = 1'b0;
                        r_d          = '0;
                        c_d          = '0;
                    end else begin
                        dump_data_d  = mem_q[r_q][c_q];
                        dump_valid_d = 1'b1;
                        dump_last_d  = at_end;
                        r_d          = r_step;
                        c_d          = c_step;
                    end
                end
            end
            default: state_d = S_IDLE;
        endcase

        if (flush_i) begin
            state_d      = S_IDLE;
            r_d          = '0;
            c_d          = '0;
            dump_valid_d = 1'b0;
            dump_last_d  = 1'b0;
            rd_valid_d   = 1'b0;
            err_d        = 1'b0;
            row_we       = 1'b0;
            elem_we      = 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q      <= S_IDLE;
            r_q          <= '0;
            c_q          <= '0;
            dump_data_q  <= '0;
            dump_valid_q <= 1'b0;
            dump_last_q  <= 1'b0;
            rd_row_q     <= '0;
            rd_addr_q    <= '0;
            rd_valid_q   <= 1'b0;
            err_q        <= 1'b0;
        end else begin
            state_q      <= state_d;
            r_q          <= r_d;
            c_q          <= c_d;
            dump_data_q  <= dump_data_d;
            dump_valid_q <= dump_valid_d;
            dump_last_q  <= dump_last_d;
            rd_row_q     <= rd_row_d;
            rd_addr_q    <= rd_addr_d;
            rd_valid_q   <= rd_valid_d;
            err_q        <= err_d;
        end
    end

    // Storage is deliberately left out of reset so partial loads survive an abort
    always_ff @(posedge clk_i) begin
        if (row_we)  mem_q[wr_addr_i] <= wr_row_i;
        if (elem_we) mem_q[r_q][c_q]  <= load_data_i;
    end

    assign rd_row_o       = rd_row_q;
    assign rd_addr_o      = rd_addr_q;
    assign rd_row_valid_o = rd_valid_q;
    assign load_ready_o   = (state_q == S_LOAD);
    assign dump_data_o    = dump_data_q;
    assign dump_valid_o   = dump_valid_q;
    assign dump_last_o    = dump_last_q;
    assign busy_o         = (state_q != S_IDLE);
    assign err_o          = err_q;

endmodule
